// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment code table, direction codes and FSM states for seg_monitor
package seg_pkg;
  localparam int unsigned NUM_DIGITS = 16;

  // Entry i is the {a,b,c,d,e,f,g} code that draws hex digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_JUMP = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOCKED
  } state_t;
endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational 7-segment code to hex digit decoder with legality flag
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (code == SEG_TABLE[i]) begin
        digit = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_monitor.sv
// rtl/seg_monitor.sv - debounced 7-segment display monitor; SEG_MONITOR_DIR_EN enables step direction and jump counting
module seg_monitor
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  output logic [3:0] value,
  output logic       dp_out,
  output logic       valid,
  output logic       bad,
  output logic [1:0] dir,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  // Sample layout: [8] cs, [7:1] a..g, [0] dp
  logic [8:0] sync1, sync2, prev;
  logic [7:0] cnt, cnt_n, last_pat;
  logic       acc_any, accept, legal, err_inc;
  logic [3:0] digit;
  state_t     state, state_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {cs, a, b, c, d, e, f, g, dp};
      sync2 <= sync1;
    end
  end

  seg_decode u_decode (
    .code  (sync2[7:1]),
    .digit (digit),
    .legal (legal)
  );

  // cs is part of the sample, so releasing cs restarts a full window.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (sync2[8]) begin
      cnt_n   = 8'd0;
      state_n = acc_any ? ST_SETTLE : ST_IDLE;
    end else if (sync2 != prev) begin
      cnt_n   = 8'd0;
      state_n = ST_SETTLE;
    end else if (state == ST_SETTLE) begin
      cnt_n = cnt + 8'd1;
      if (cnt_n == STABLE_N) begin
        state_n = ST_LOCKED;
        accept  = !(acc_any && sync2[7:0] == last_pat);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      prev     <= '0;
      acc_any  <= 1'b0;
      last_pat <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= sync2;
      if (accept) begin
        acc_any  <= 1'b1;
        last_pat <= sync2[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value   <= 4'd0;
      dp_out  <= 1'b0;
      valid   <= 1'b0;
      bad     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      valid <= accept && legal;
      bad   <= accept && !legal;
      if (accept) begin
        dp_out <= sync2[0];
        if (legal) value <= digit;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef SEG_MONITOR_DIR_EN
  logic [1:0] dir_q, dir_n;
  logic [3:0] val_up, val_dn;
  logic       val_any;

  assign val_up = value + 4'd1;
  assign val_dn = value - 4'd1;

  // Same digit can only be re-accepted because dp changed.
  always_comb begin
    dir_n = DIR_NONE;
    if (val_any && digit != value) begin
      if (digit == val_up)      dir_n = DIR_UP;
      else if (digit == val_dn) dir_n = DIR_DOWN;
      else                      dir_n = DIR_JUMP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q   <= DIR_NONE;
      val_any <= 1'b0;
    end else if (accept && legal) begin
      dir_q   <= dir_n;
      val_any <= 1'b1;
    end
  end

  assign dir     = dir_q;
  assign err_inc = accept && (!legal || dir_n == DIR_JUMP);
`else
  assign dir     = DIR_NONE;
  assign err_inc = accept && !legal;
`endif

endmodule

// File: tb/tb_seg_monitor.sv
// tb/tb_seg_monitor.sv - directed self-checking bench for seg_monitor
module tb_seg_monitor;
  localparam int N = 4;
`ifdef SEG_MONITOR_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif
  localparam logic [1:0] DU = DIR_EN ? 2'b01 : 2'b00;
  localparam logic [1:0] DD = DIR_EN ? 2'b10 : 2'b00;
  localparam logic [1:0] DJ = DIR_EN ? 2'b11 : 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs  = 1'b0;
  logic [6:0] seg = 7'h00;
  logic       dp  = 1'b0;
  logic [3:0] value;
  logic       dp_out, valid, bad;
  logic [1:0] dir;
  logic [7:0] err_cnt;

  int  vectors = 0;
  int  miscompares = 0;
  bit  both_seen = 1'b0;
  int  e_err = 0;
  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg_monitor #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .dp(dp), .value(value), .dp_out(dp_out), .valid(valid), .bad(bad),
    .dir(dir), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".value"},  value,   0);
    check({tag, ".dp_out"}, dp_out,  0);
    check({tag, ".valid"},  valid,   0);
    check({tag, ".bad"},    bad,     0);
    check({tag, ".dir"},    dir,     0);
    check({tag, ".err"},    err_cnt, 0);
  endtask

  task automatic observe(input int cycles, output int nv, output int nb, output int lat);
    nv = 0; nb = 0; lat = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (valid && bad) both_seen = 1'b1;
      if ((valid || bad) && lat == 0) lat = i;
      nv += int'(valid);
      nb += int'(bad);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] s, input logic p, input int cyc,
                      input int ev, input int eb, input logic [3:0] eval, input logic edp,
                      input logic [1:0] edir);
    int nv, nb, lat;
    seg = s;
    dp  = p;
    observe(cyc, nv, nb, lat);
    check({tag, ".valid_n"}, nv, ev);
    check({tag, ".bad_n"},   nb, eb);
    if (ev + eb > 0) check({tag, ".latency"}, lat, N + 3);
    check({tag, ".value"},  value,   eval);
    check({tag, ".dp_out"}, dp_out,  edp);
    check({tag, ".dir"},    dir,     edir);
    check({tag, ".err"},    err_cnt, e_err);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  initial begin
    int nv, nb, lat;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    step("first", 7'h7E, 1'b0, 10, 1, 0, 4'd0, 1'b0, 2'b00);
    for (int k = 1; k < 16; k++) step("count_up", codes[k], 1'b0, 8, 1, 0, 4'(k), 1'b0, DU);
    step("wrap_f0", 7'h7E, 1'b0, 8, 1, 0, 4'd0, 1'b0, DU);

    step("one", 7'h30, 1'b0, 10, 1, 0, 4'd1, 1'b0, DU);
    seg = 7'h00;
    observe(2, nv, nb, lat);
    check("glitch.pulses", nv + nb, 0);
    step("glitch_back", 7'h30, 1'b0, 10, 0, 0, 4'd1, 1'b0, DU);

    step("two", 7'h6D, 1'b0, 8, 1, 0, 4'd2, 1'b0, DU);
    step("three", 7'h79, 1'b0, 8, 1, 0, 4'd3, 1'b0, DU);
    e_err = sat_inc(e_err);
    step("illegal", 7'h00, 1'b0, 8, 0, 1, 4'd3, 1'b0, DU);
    if (DIR_EN) e_err = sat_inc(e_err);
    step("jump5", 7'h5B, 1'b0, 8, 1, 0, 4'd5, 1'b0, DJ);
    step("dp_only", 7'h5B, 1'b1, 8, 1, 0, 4'd5, 1'b1, 2'b00);
    step("down4", 7'h33, 1'b0, 8, 1, 0, 4'd4, 1'b0, DD);
    if (DIR_EN) e_err = sat_inc(e_err);
    step("jump0", 7'h7E, 1'b0, 8, 1, 0, 4'd0, 1'b0, DJ);
    step("down_0f", 7'h47, 1'b0, 8, 1, 0, 4'd15, 1'b0, DD);

    cs = 1'b1;
    step("cs_high", 7'h30, 1'b0, 10, 0, 0, 4'd15, 1'b0, DD);
    cs = 1'b0;
    if (DIR_EN) e_err = sat_inc(e_err);
    step("cs_release", 7'h30, 1'b0, 10, 1, 0, 4'd1, 1'b0, DJ);

    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        step("sat", 7'h7E, 1'b0, 8, 1, 0, 4'd0, 1'b0, DD);
      end else begin
        if (DIR_EN) e_err = sat_inc(e_err);
        if (i % 2 == 1) step("sat", 7'h7F, 1'b0, 8, 1, 0, 4'd8, 1'b0, DJ);
        else            step("sat", 7'h7E, 1'b0, 8, 1, 0, 4'd0, 1'b0, DJ);
      end
    end
    check("sat.err_final", err_cnt, DIR_EN ? 255 : 1);
    e_err = sat_inc(e_err);
    step("sat_bad", 7'h00, 1'b0, 8, 0, 1, 4'd8, 1'b0, DJ);

    seg = 7'h6D;
    observe(5, nv, nb, lat);
    check("mid_settle.pulses", nv + nb, 0);
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    e_err = 0;
    step("post_reset", 7'h6D, 1'b0, 12, 1, 0, 4'd2, 1'b0, 2'b00);

    check("exclusive", both_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
